// File: rtl/router_pkg.sv
// Shared router definitions: injection-channel and flow-control field
// offsets, the injector FSM state type and a small width helper.
package router_pkg;

    // Injection channel layout, MSB-first: valid, head, tail, vc, data, parity.
    // Only the fixed leading fields are given here. The data field starts
    // right after the vc field, and the parity bit follows the data field.
    localparam int ch_valid = 0;
    localparam int ch_head  = 1;
    localparam int ch_tail  = 2;
    localparam int ch_vc    = 3;

    // Credit-return layout, MSB-first: valid, vc.
    localparam int fc_valid = 0;
    localparam int fc_vc    = 1;

    // Packet framing state of the injector.
    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } inj_state_e;

    // Index width for n items; never returns zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-VC downstream credit counter. It resets to full, is taken by a sent
// flit and given back by a credit return. The overflow output flags a
// return that arrives while the counter is already full.
module credit_counter #(
    parameter int max_credits = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               dec,
    input  logic                               inc,
    output logic [$clog2(max_credits + 1)-1:0] count,
    output logic                               overflow
);

    localparam int               cnt_w = $clog2(max_credits + 1);
    localparam logic [cnt_w-1:0] full  = cnt_w'(max_credits);

    // A full counter means the downstream buffer is empty, so any return is bogus.
    assign overflow = inc && (count == full);

    // Track free downstream slots. A simultaneous take and give cancel out,
    // and the count saturates at full.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // flop samples the pre-edge values of the others.
        if (reset) begin
            count <= full;
        end else if (inc && !dec && (count != full)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/nic_flit_injector.sv
// NIC flit injector. It takes host flits through a valid/ready handshake,
// frames them into packets (head/body/tail), applies per-VC credit flow
// control and drives one registered flit per cycle into a router input
// port. Protocol violations latch a sticky error flag that blocks
// further injection until reset.
module nic_flit_injector
    import router_pkg::*;
#(
    parameter int num_vcs            = 4,
    parameter int credits_per_vc     = 16,
    parameter int max_payload_length = 4,
    parameter int flit_data_width    = 64
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 host_valid,
    output logic                                                 host_ready,
    input  logic [0:flit_data_width-1]                           host_data,
    input  logic [0:idx_width(num_vcs)-1]                        host_vc,
    input  logic                                                 host_last,
    output logic [0:flit_data_width+idx_width(num_vcs)+3]        channel_out,
    input  logic [0:idx_width(num_vcs)]                          flow_ctrl_in,
    output logic                                                 error
);

    localparam int vc_w      = idx_width(num_vcs);
    localparam int cnt_w     = $clog2(credits_per_vc + 1);
    localparam int pl_w      = idx_width(max_payload_length);
    localparam int ch_data   = ch_vc + vc_w;
    localparam int ch_parity = ch_data + flit_data_width;

    localparam logic [pl_w-1:0] pl_last = pl_w'(max_payload_length - 1);

    inj_state_e         state;
    logic [vc_w-1:0]    lock_vc;
    logic [pl_w-1:0]    payload_cnt;
    logic [cnt_w-1:0]   credit [num_vcs];
    logic [num_vcs-1:0] overflow;

    logic               vc_ok;
    logic               accept;
    logic               vc_violation;
    logic               forced_tail;
    logic               ret_valid;
    logic [vc_w-1:0]    ret_vc;

    assign ret_valid = flow_ctrl_in[fc_valid];
    assign ret_vc    = flow_ctrl_in[fc_vc +: vc_w];

    // Ready when the target VC has a credit, the packet stays on its locked
    // VC and nothing has gone wrong yet.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no
        // latch is inferred.
        vc_ok      = (state == IDLE) || (host_vc == lock_vc);
        host_ready = !reset && !error && vc_ok && (credit[host_vc] != '0);
    end

    assign accept       = host_valid && host_ready;
    assign vc_violation = (state == BODY) && host_valid && (host_vc != lock_vc);
    assign forced_tail  = accept && (state == BODY) && !host_last
                          && (payload_cnt == pl_last);

    // One credit counter per VC. The handshake takes a credit and a matching return gives one back.
    for (genvar i = 0; i < num_vcs; i++) begin : g_credit
        credit_counter #(
            .max_credits (credits_per_vc)
        ) u_credit (
            .clk      (clk),
            .reset    (reset),
            .dec      (accept && (host_vc == vc_w'(i))),
            .inc      (ret_valid && (ret_vc == vc_w'(i))),
            .count    (credit[i]),
            .overflow (overflow[i])
        );
    end

    // Packet framing FSM with a registered channel output and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lock_vc     <= '0;
            payload_cnt <= '0;
            channel_out <= '0;
            error       <= 1'b0;
        end else begin
            channel_out <= '0;

            if (vc_violation || forced_tail || (|overflow)) begin
                error <= 1'b1;
            end

            if (accept) begin
                channel_out[ch_valid]                  <= 1'b1;
                channel_out[ch_vc +: vc_w]             <= host_vc;
                channel_out[ch_data +: flit_data_width] <= host_data;
                channel_out[ch_parity]                 <= ^host_data;

                case (state)
                    IDLE: begin
                        channel_out[ch_head] <= 1'b1;
                        channel_out[ch_tail] <= host_last;
                        if (!host_last) begin
                            state       <= BODY;
                            lock_vc     <= host_vc;
                            payload_cnt <= '0;
                        end
                    end
                    BODY: begin
                        payload_cnt <= payload_cnt + 1'b1;
                        // A packet that reaches the payload limit is cut short.
                        if (host_last || forced_tail) begin
                            channel_out[ch_tail] <= 1'b1;
                            state                <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nic_flit_injector.sv
// Directed self-checking bench for nic_flit_injector.
module tb_nic_flit_injector;
    import router_pkg::*;

    logic        clk;
    logic        reset;
    logic        host_valid;
    logic        host_ready;
    logic [0:63] host_data;
    logic [0:1]  host_vc;
    logic        host_last;
    logic [0:69] channel_out;
    logic [0:2]  flow_ctrl_in;
    logic        error;

    int n_checks;
    int n_errors;

    nic_flit_injector dut (
        .clk          (clk),
        .reset        (reset),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_data    (host_data),
        .host_vc      (host_vc),
        .host_last    (host_last),
        .channel_out  (channel_out),
        .flow_ctrl_in (flow_ctrl_in),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] vc, input logic [63:0] d,
                         input logic last, input logic fcv, input logic [1:0] fcvc);
        host_valid   = v;
        host_vc      = vc;
        host_data    = d;
        host_last    = last;
        flow_ctrl_in = {fcv, fcvc};
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 2'd0);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected valid flit; the parity bit is given by hand for each vector.
    function automatic logic [69:0] flit(input logic h, input logic t, input logic [1:0] vc,
                                         input logic [63:0] d, input logic p);
        return {1'b1, h, t, vc, d, p};
    endfunction

    task automatic credits_return(input logic [1:0] vc, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 2'd0, 64'h0, 1'b0, 1'b1, vc);
            tick();
        end
        idle();
    endtask

    task automatic check_all_credits(input string tag);
        for (int i = 0; i < 4; i++) check(tag, dut.credit[i], 16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset with a flit offered: ready must stay low and nothing gets sent.
        reset = 1'b1;
        drive(1'b1, 2'd0, 64'h1, 1'b1, 1'b0, 2'd0);
        #1;
        check("ready_in_reset", host_ready, 0);
        tick();
        tick();
        check("rst_channel", channel_out, 0);
        check("rst_error", error, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b0;
        idle();
        check_all_credits("rst_credit");

        // 3-flit packet on VC2.
        drive(1'b1, 2'd2, 64'h1, 1'b0, 1'b0, 2'd0);
        #1;
        check("s1_ready", host_ready, 1);
        tick();
        check("s1_head", channel_out, flit(1, 0, 2, 64'h1, 1'b1));
        drive(1'b1, 2'd2, 64'h3, 1'b0, 1'b0, 2'd0);
        tick();
        check("s1_body", channel_out, flit(0, 0, 2, 64'h3, 1'b0));
        drive(1'b1, 2'd2, 64'hFF00, 1'b1, 1'b0, 2'd0);
        tick();
        check("s1_tail", channel_out, flit(0, 1, 2, 64'hFF00, 1'b0));
        idle();
        check("s1_credit2", dut.credit[2], 13);
        tick();
        check("s1_quiet", channel_out, 0);
        credits_return(2'd2, 3);
        check("s1_restore", dut.credit[2], 16);

        // Drain VC0 with 16 single-flit packets.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd0, 64'(i), 1'b1, 1'b0, 2'd0);
            tick();
        end
        check("s2_16th", channel_out, flit(1, 1, 0, 64'hF, 1'b0));
        check("s2_credit0", dut.credit[0], 0);
        drive(1'b1, 2'd0, 64'h5, 1'b1, 1'b0, 2'd0);
        #1;
        check("s2_vc0_blocked", host_ready, 0);
        tick();
        check("s2_no_send", channel_out, 0);
        drive(1'b1, 2'd1, 64'h7, 1'b1, 1'b0, 2'd0);
        #1;
        check("s2_vc1_ready", host_ready, 1);
        tick();
        check("s2_vc1_flit", channel_out, flit(1, 1, 1, 64'h7, 1'b1));
        drive(1'b0, 2'd0, 64'h0, 1'b0, 1'b1, 2'd0);
        tick();
        drive(1'b1, 2'd0, 64'h5, 1'b1, 1'b0, 2'd0);
        #1;
        check("s2_vc0_reopen", host_ready, 1);
        tick();
        check("s2_vc0_flit", channel_out, flit(1, 1, 0, 64'h5, 1'b0));
        idle();
        credits_return(2'd0, 16);
        credits_return(2'd1, 1);
        check_all_credits("s2_restore");

        // Simultaneous take and give on VC1 at credit 5.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 2'd1, 64'h1, 1'b1, 1'b0, 2'd0);
            tick();
        end
        idle();
        check("s3_credit1_pre", dut.credit[1], 5);
        drive(1'b1, 2'd1, 64'h3, 1'b1, 1'b1, 2'd1);
        tick();
        idle();
        check("s3_credit1_post", dut.credit[1], 5);
        check("s3_flit", channel_out, flit(1, 1, 1, 64'h3, 1'b0));
        credits_return(2'd1, 11);
        check("s3_restore", dut.credit[1], 16);

        // Reset mid-packet on VC0, together with a handshake and a credit return.
        drive(1'b1, 2'd0, 64'h1, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b1, 2'd0, 64'h3, 1'b0, 1'b0, 2'd0);
        tick();
        check("s5_state_body", dut.state, BODY);
        reset = 1'b1;
        drive(1'b1, 2'd0, 64'h7, 1'b1, 1'b1, 2'd0);
        tick();
        reset = 1'b0;
        idle();
        check("s5_channel", channel_out, 0);
        check("s5_state", dut.state, IDLE);
        check_all_credits("s5_credit");
        drive(1'b1, 2'd0, 64'h3, 1'b0, 1'b0, 2'd0);
        tick();
        check("s5_new_head", channel_out, flit(1, 0, 0, 64'h3, 1'b0));
        drive(1'b1, 2'd0, 64'h1, 1'b1, 1'b0, 2'd0);
        tick();
        idle();
        credits_return(2'd0, 2);
        check("s5_error_clear", error, 0);

        // Payload limit: head plus 4 body flits without host_last.
        drive(1'b1, 2'd1, 64'h1, 1'b0, 1'b0, 2'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 64'h3, 1'b0, 1'b0, 2'd0);
            tick();
        end
        check("s4_body_no_tail", channel_out, flit(0, 0, 1, 64'h3, 1'b0));
        check("s4_no_error_yet", error, 0);
        drive(1'b1, 2'd1, 64'h7, 1'b0, 1'b0, 2'd0);
        tick();
        check("s4_forced_tail", channel_out, flit(0, 1, 1, 64'h7, 1'b1));
        check("s4_error", error, 1);
        drive(1'b1, 2'd1, 64'h1, 1'b1, 1'b0, 2'd0);
        #1;
        check("s4_ready_low", host_ready, 0);
        tick();
        check("s4_blocked", channel_out, 0);
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        check("s4_reset_error", error, 0);

        // Credit return into a full counter.
        drive(1'b0, 2'd0, 64'h0, 1'b0, 1'b1, 2'd3);
        tick();
        idle();
        check("s6_error", error, 1);
        check("s6_credit3", dut.credit[3], 16);
        tick();
        check("s6_error_sticky", error, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nic_flit_injector.md
NIC_FLIT_INJECTOR -- requirements
Module: nic_flit_injector

Interface
REQ-001 The block SHALL have parameter num_vcs, default 4: number of virtual channels on the link.
REQ-002 The block SHALL have parameter credits_per_vc, default 16: downstream buffer depth per VC (64 total).
REQ-003 The block SHALL have parameter max_payload_length, default 4: maximum number of non-head flits per packet.
REQ-004 The block SHALL have parameter flit_data_width, default 64: width of the flit data field.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port host_valid, input, 1 bit: the host presents a flit.
REQ-008 The block SHALL have port host_ready, output, 1 bit: the block accepts the presented flit this cycle.
REQ-009 The block SHALL have port host_data, input, [0:63]: flit data, where the head flit carries the destination address in bits [0:3].
REQ-010 The block SHALL have port host_vc, input, [0:1]: the target VC.
REQ-011 The block SHALL have port host_last, input, 1 bit: the flit is the packet tail.
REQ-012 The block SHALL have port channel_out, output, [0:69]: injection channel into one router input port, formatted as [0] valid, [1] head, [2] tail, [3:4] vc, [5:68] data, [69] even parity over [5:68].
REQ-013 The block SHALL have port flow_ctrl_in, input, [0:2]: credit return, formatted as [0] valid, [1:2] vc.
REQ-014 The block SHALL have port error, output, 1 bit: sticky protocol error flag.

Function
REQ-015 The block SHALL transfer a flit only when host_valid and host_ready are both high on the same rising edge.
REQ-016 host_ready SHALL be high only when credit[host_vc] > 0 and no error is latched.
REQ-017 host_ready SHALL be combinational from host_vc, the credit counters, the FSM state and error.
REQ-018 The block SHALL drive each accepted flit on channel_out exactly 1 cycle after the handshake, from a register.
REQ-019 channel_out SHALL be all zeros in every cycle with no transfer.
REQ-020 The block SHALL have FSM states IDLE and BODY, and SHALL set head=1 on a flit accepted in IDLE.
REQ-021 In IDLE, a flit accepted with host_last=0 SHALL move the FSM to BODY, latch host_vc as lock_vc and clear payload_cnt.
REQ-022 In IDLE, a flit accepted with host_last=1 SHALL be emitted as a single-flit packet (head=1, tail=1), and the FSM SHALL stay in IDLE.
REQ-023 In BODY, each accepted flit SHALL increment payload_cnt, and a flit with host_last=1 SHALL set tail=1 and return the FSM to IDLE.
REQ-024 In BODY, host_vc differing from lock_vc while host_valid is high SHALL set error and SHALL not be accepted.
REQ-025 In BODY, a flit accepted when payload_cnt == max_payload_length-1 with host_last=0 SHALL be emitted as tail=1 (forced tail), SHALL set error, and SHALL return the FSM to IDLE.
REQ-026 Each VC SHALL have its own credit counter, range 0..credits_per_vc, $clog2(credits_per_vc+1) bits wide.
REQ-027 A credit counter SHALL decrement by 1 on a handshake on that VC.
REQ-028 A credit counter SHALL increment by 1 on flow_ctrl_in valid for that VC.
REQ-029 A simultaneous decrement and increment on the same VC SHALL leave the counter unchanged.
REQ-030 A credit return to a counter already at credits_per_vc SHALL leave the counter saturated and SHALL set error.
REQ-031 Once set, error SHALL remain high until reset.
REQ-032 While error is high, host_ready SHALL be 0, and credit returns SHALL still be counted.

Reset
REQ-033 While reset is high at a clock edge, the block SHALL set channel_out=0, error=0, FSM=IDLE, payload_cnt=0, lock_vc=0 and all credits=credits_per_vc.
REQ-034 While reset is high, host_ready SHALL be 0.
REQ-035 A reset during BODY SHALL abandon the packet with no tail emitted.
REQ-036 Reset SHALL take priority over a handshake and a credit return in the same cycle.

Structure
REQ-037 The channel field offsets, the flow-control field offsets and the FSM state enum SHALL live in the shared package router_pkg.
REQ-038 The per-VC credit counter SHALL be a sub-module named credit_counter, instantiated num_vcs times.

Verification
REQ-039 Bench scenario: 3-flit packet on VC2, credits full -> channel_out valid on cycles t+1..t+3 with head/-/tail respectively, vc=2, correct parity, credit[2]=13.
REQ-040 Bench scenario: 16 single-flit packets on VC0 with no returns -> 16th accepted, host_ready=0 for VC0 while VC1 is still accepted; one return on VC0 -> host_ready=1 the next cycle.
REQ-041 Bench scenario: handshake on VC1 and flow_ctrl_in=(1,VC1) in the same cycle with credit[1]=5 -> credit[1] stays 5.
REQ-042 Bench scenario: head plus 4 payload flits with host_last never set -> 5th flit is emitted with tail=1, error=1, and host_ready=0 afterwards.
REQ-043 Bench scenario: credit return on VC3 while credit[3]=16 -> error=1 next cycle, credit[3] stays 16.
REQ-044 Bench scenario: reset asserted mid-packet on VC0 after 2 flits -> next cycle channel_out=0, all credits=16, FSM=IDLE, and a new head on VC0 is accepted with head=1.
